// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Width of an iteration counter that can hold the value WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_div_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (
    output start, sign, a, b,
    input  busy, done, q, r, div_zero
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, q, r, div_zero
  );

endinterface

// File: rtl/seq_div_cneg.sv
// Conditional two's-complement negator: y = en ? -x : x.
module div_cneg #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
// Build option: define SEQ_DIV_SIGNED_EN to honour the 'sign' input
// (signed DIV); otherwise every operand is treated as unsigned and the
// negators collapse to wires, with the FIX cycle kept so latency is equal.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_div_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  div_state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;     // partial remainder
  logic [WIDTH-1:0] dvd;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;     // divisor magnitude
  logic             neg_q;
  logic             neg_r;

  logic             sign_eff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic             last;
  logic             dvs_zero;

`ifdef SEQ_DIV_SIGNED_EN
  assign sign_eff = bus.sign;
`else
  assign sign_eff = 1'b0;
`endif

  // Trial subtraction: bit WIDTH of the difference is the borrow.
  assign sh       = {rem, dvd[WIDTH-1]};
  assign diff     = sh - {1'b0, dvs};
  assign qbit     = ~diff[WIDTH];
  assign last     = (cnt == CW'(WIDTH - 1));
  assign dvs_zero = (dvs == '0);
  assign bus.busy = (state == CALC);

  div_cneg #(.WIDTH(WIDTH)) u_neg_a (
    .en (sign_eff & bus.a[WIDTH-1]),
    .x  (bus.a),
    .y  (a_mag)
  );

  div_cneg #(.WIDTH(WIDTH)) u_neg_b (
    .en (sign_eff & bus.b[WIDTH-1]),
    .x  (bus.b),
    .y  (b_mag)
  );

  // Divide-by-zero leaves the quotient as all ones, so its sign fix is skipped.
  div_cneg #(.WIDTH(WIDTH)) u_neg_q (
    .en (neg_q & ~dvs_zero),
    .x  (dvd),
    .y  (q_fix)
  );

  // Remainder is |a| after a zero divide; negating it restores the original a.
  div_cneg #(.WIDTH(WIDTH)) u_neg_r (
    .en (neg_r),
    .x  (rem),
    .y  (r_fix)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (last)      state_nx = FIX;
      FIX:                    state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Operand capture and one restoring iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt   <= '0;
            rem   <= '0;
            dvd   <= a_mag;
            dvs   <= b_mag;
            neg_q <= sign_eff & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r <= sign_eff & bus.a[WIDTH-1];
          end
        end
        CALC: begin
          rem <= qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], qbit};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers and the one-cycle done pulse, loaded from FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done     <= 1'b0;
      bus.q        <= '0;
      bus.r        <= '0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= (state == FIX);
      if (state == FIX) begin
        bus.q        <= q_fix;
        bus.r        <= r_fix;
        bus.div_zero <= dvs_zero;
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: vector table plus multi-cycle corner sequences.
module tb_seq_div;
  import div_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  seq_div_if #(.WIDTH(W)) bus();

  seq_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference divider built from the simulator's own arithmetic.
  function automatic vec_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    logic s;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0] min_v;
`ifdef SEQ_DIV_SIGNED_EN
    s = sgn;
`else
    s = 1'b0;
`endif
    sa = a;
    sb = b;
    min_v = {1'b1, {(W-1){1'b0}}};
    v.sgn = sgn;
    v.a = a;
    v.b = b;
    v.z = 1'b0;
    if (b == '0) begin
      v.q = '1;
      v.r = a;
      v.z = 1'b1;
    end else if (s) begin
      if (a == min_v && b == '1) begin
        v.q = min_v;
        v.r = '0;
      end else begin
        v.q = sa / sb;
        v.r = sa % sb;
      end
    end else begin
      v.q = a / b;
      v.r = a % b;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
    end
  endtask

  // Called at a negedge: present operands with start, push the expectation.
  task automatic drive(input vec_t v);
    exp_t e;
    bus.sign  = v.sgn;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.start = 1'b1;
    e.q   = v.q;
    e.r   = v.r;
    e.z   = v.z;
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sign  = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done, pop the scoreboard and compare; returns at the done negedge.
  task automatic collect(input string nm, output int bcnt);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
      @(negedge clk);
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.timeout: got no done, want done within 80 cycles", nm);
    end else if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.unexpected_done: got done, want no pending operation", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, ".q"},    bus.q, e.q);
      chk({nm, ".r"},    bus.r, e.r);
      chk({nm, ".dz"},   W'(bus.div_zero), W'(e.z));
      chk({nm, ".lat"},  W'(cyc - e.acc), W'(LAT));
      chk({nm, ".busy"}, W'(bus.busy), W'(0));
    end
  endtask

  task automatic no_done(input string nm, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk(nm, W'(cnt), W'(0));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".q"},    bus.q, '0);
    chk({nm, ".r"},    bus.r, '0);
    chk({nm, ".dz"},   W'(bus.div_zero), W'(0));
    chk({nm, ".done"}, W'(bus.done), W'(0));
    chk({nm, ".busy"}, W'(bus.busy), W'(0));
  endtask

  initial begin
    int   bc;
    vec_t v;
    n_chk     = 0;
    n_fail    = 0;
    cyc       = 0;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b1;

    tbl[0]  = model(1'b1, 32'hFFFF_FFF9, 32'd2);
    tbl[1]  = model(1'b1, 32'd12,        32'hFFFF_FFFE);
    tbl[2]  = model(1'b0, 32'd9,         32'd0);
    tbl[3]  = model(1'b1, 32'd9,         32'd0);
    tbl[4]  = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    tbl[5]  = model(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    tbl[6]  = model(1'b1, 32'hFFFF_FFF7, 32'd0);
    tbl[7]  = model(1'b1, 32'hFFFF_FF9C, 32'd7);
    tbl[8]  = model(1'b1, 32'd100,       32'hFFFF_FFF9);
    tbl[9]  = model(1'b0, 32'hFFFF_FFFF, 32'd1);
    tbl[10] = model(1'b0, 32'd5,         32'd10);
    tbl[11] = model(1'b1, 32'h8000_0000, 32'd1);

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic unsigned case with latency and busy-length checks.
    drive(model(1'b0, 32'd100, 32'd7));
    collect("u100_7", bc);
    chk("u100_7.busy_cycles", W'(bc), W'(W));
    chk("u100_7.q_const", bus.q, 32'd14);
    chk("u100_7.r_const", bus.r, 32'd2);

    // Vector table, each new start issued in the previous done cycle.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      collect($sformatf("tbl%0d", i), bc);
    end

    // start and operand changes in the middle of CALC are ignored.
    drive(model(1'b0, 32'd1000, 32'd33));
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd7;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    collect("midcalc", bc);
    chk("midcalc.q_const", bus.q, 32'd30);
    no_done("midcalc.no_extra_done", 40);

    // Asynchronous reset in the middle of CALC aborts the operation.
    drive(model(1'b0, 32'd12345, 32'd11));
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    void'(sbq.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_done("abort.no_done", 40);
    drive(model(1'b0, 32'd50, 32'd5));
    collect("after_abort", bc);
    chk("after_abort.q_const", bus.q, 32'd10);
    chk("after_abort.r_const", bus.r, 32'd0);

    // start held high: second operands presented in the done cycle.
    @(negedge clk);
    v = model(1'b0, 32'd20, 32'd3);
    bus.sign  = 1'b0;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.start = 1'b1;
    sbq.push_back('{q: v.q, r: v.r, z: v.z, acc: cyc + 1});
    @(negedge clk);
    collect("hold1", bc);
    chk("hold1.q_const", bus.q, 32'd6);
    v = model(1'b0, 32'd21, 32'd4);
    bus.a = v.a;
    bus.b = v.b;
    sbq.push_back('{q: v.q, r: v.r, z: v.z, acc: cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
    collect("hold2", bc);
    chk("hold2.q_const", bus.q, 32'd5);
    chk("hold2.r_const", bus.r, 32'd1);
    chk("scoreboard_empty", W'(sbq.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
